// File: rtl/jt12_gain_mixer.sv
// Four-channel signed mixer: per-channel MSB alignment and 4.4 gain, then sum,
// divide by 16 and clip to the output width. Two-stage pipeline gated by cen.
module jt12_gain_mixer #(
  parameter int w0   = 16,
  parameter int w1   = 16,
  parameter int w2   = 16,
  parameter int w3   = 16,
  parameter int wout = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cen,
  input  logic signed [w0-1:0]   ch0,
  input  logic signed [w1-1:0]   ch1,
  input  logic signed [w2-1:0]   ch2,
  input  logic signed [w3-1:0]   ch3,
  input  logic        [7:0]      gain0,
  input  logic        [7:0]      gain1,
  input  logic        [7:0]      gain2,
  input  logic        [7:0]      gain3,
  output logic signed [wout-1:0] mixed
);

  localparam int wp = wout + 9;
  localparam int ws = wout + 11;

  logic signed [wout-1:0] ext[4];
  logic signed [wout-1:0] aligned[4];
  logic        [7:0]      gain[4];
  logic signed [wp-1:0]   prod_next[4];
  logic signed [wp-1:0]   prod_reg[4];
  logic signed [ws-1:0]   sum;
  logic signed [ws-1:0]   shifted;
  logic signed [wout-1:0] mixed_next;
  logic signed [wout-1:0] mixed_reg;

  // Sign-extend first, then shift: the extension bits fall off the top,
  // leaving the channel MSB on bit wout-1 with zeros below.
  assign ext[0] = wout'(ch0);
  assign ext[1] = wout'(ch1);
  assign ext[2] = wout'(ch2);
  assign ext[3] = wout'(ch3);

  assign aligned[0] = ext[0] <<< (wout - w0);
  assign aligned[1] = ext[1] <<< (wout - w1);
  assign aligned[2] = ext[2] <<< (wout - w2);
  assign aligned[3] = ext[3] <<< (wout - w3);

  assign gain[0] = gain0;
  assign gain[1] = gain1;
  assign gain[2] = gain2;
  assign gain[3] = gain3;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_prod
      logic signed [8:0] gain_s;
      assign gain_s        = $signed({1'b0, gain[gi]});
      assign prod_next[gi] = wp'(aligned[gi]) * wp'(gain_s);

      always_ff @(posedge clk) begin
        if (rst) begin
          prod_reg[gi] <= '0;
        end else if (cen) begin
          prod_reg[gi] <= prod_next[gi];
        end
      end
    end
  endgenerate

  assign sum = ws'(prod_reg[0]) + ws'(prod_reg[1])
             + ws'(prod_reg[2]) + ws'(prod_reg[3]);
  assign shifted = sum >>> 4;

  // In range only if every bit above the output sign bit matches it.
  always_comb begin
    mixed_next = shifted[wout-1:0];
    if (shifted[ws-1:wout-1] != {(ws-wout+1){shifted[ws-1]}}) begin
      mixed_next = shifted[ws-1] ? {1'b1, {(wout-1){1'b0}}}
                                 : {1'b0, {(wout-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mixed_reg <= '0;
    end else if (cen) begin
      mixed_reg <= mixed_next;
    end
  end

  assign mixed = mixed_reg;

endmodule

// File: tb/tb_jt12_gain_mixer.sv
// Directed bench for jt12_gain_mixer: one all-16-bit instance and one with
// narrow ch2/ch3 (11 and 8 bits) to exercise MSB alignment.
module tb_jt12_gain_mixer;

  logic               clk = 1'b0;
  logic               rst;
  logic               cen;
  logic signed [15:0] ch0, ch1, ch2, ch3;
  logic signed [10:0] ch2a;
  logic signed [7:0]  ch3a;
  logic        [7:0]  gain0, gain1, gain2, gain3;
  logic signed [15:0] mixed;
  logic signed [15:0] mixed_a;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  jt12_gain_mixer #(.w0(16), .w1(16), .w2(16), .w3(16), .wout(16)) dut (
    .clk(clk), .rst(rst), .cen(cen),
    .ch0(ch0), .ch1(ch1), .ch2(ch2), .ch3(ch3),
    .gain0(gain0), .gain1(gain1), .gain2(gain2), .gain3(gain3),
    .mixed(mixed)
  );

  jt12_gain_mixer #(.w0(16), .w1(16), .w2(11), .w3(8), .wout(16)) dut_a (
    .clk(clk), .rst(rst), .cen(cen),
    .ch0(ch0), .ch1(ch1), .ch2(ch2a), .ch3(ch3a),
    .gain0(gain0), .gain1(gain1), .gain2(gain2), .gain3(gain3),
    .mixed(mixed_a)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Advance n clock edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int c0, input int c1, input int c2, input int c3,
                        input logic [7:0] g0, input logic [7:0] g1,
                        input logic [7:0] g2, input logic [7:0] g3);
    ch0 = 16'(c0); ch1 = 16'(c1); ch2 = 16'(c2); ch3 = 16'(c3);
    gain0 = g0; gain1 = g1; gain2 = g2; gain3 = g3;
  endtask

  initial begin
    rst = 1'b1; cen = 1'b0;
    ch2a = '0; ch3a = '0;
    set_in(1111, 2222, 3333, 4444, 8'h10, 8'h10, 8'h10, 8'h10);
    step(2);
    check("reset_mixed", mixed, 0);
    check("reset_mixed_a", mixed_a, 0);
    rst = 1'b0; cen = 1'b1;
    step(1);
    check("post_reset_1tick", mixed, 0);
    step(1);
    check("post_reset_2tick", mixed, 11110 >>> 0);

    // Unity gain; other channels carry data but gain 0 removes them.
    set_in(1234, 9999, -7777, 555, 8'h10, 8'h00, 8'h00, 8'h00);
    step(2);
    check("unity_pos", mixed, 1234);
    set_in(-1234, 9999, -7777, 555, 8'h10, 8'h00, 8'h00, 8'h00);
    step(2);
    check("unity_neg", mixed, -1234);

    // Alignment on the narrow instance.
    set_in(0, 0, 0, 0, 8'h00, 8'h00, 8'h10, 8'h00);
    ch2a = 11'sd100; ch3a = 8'sd0;
    step(2);
    check("align_w11", mixed_a, 3200);
    set_in(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h10);
    ch2a = 11'sd0; ch3a = -8'sd128;
    step(2);
    check("align_w8_min", mixed_a, -32768);
    ch3a = 8'sd0;

    // Gain scaling and floor rounding.
    set_in(1000, 0, 0, 0, 8'h80, 8'h00, 8'h00, 8'h00);
    step(2);
    check("gain_x8", mixed, 8000);
    set_in(1000, 0, 0, 0, 8'h08, 8'h00, 8'h00, 8'h00);
    step(2);
    check("gain_half", mixed, 500);
    set_in(-3, 0, 0, 0, 8'h08, 8'h00, 8'h00, 8'h00);
    step(2);
    check("gain_floor", mixed, -2);

    // Saturation.
    set_in(30000, 30000, 0, 0, 8'h10, 8'h10, 8'h00, 8'h00);
    step(2);
    check("sat_pos", mixed, 32767);
    set_in(-30000, -30000, 0, 0, 8'h10, 8'h10, 8'h00, 8'h00);
    step(2);
    check("sat_neg", mixed, -32768);
    set_in(32767, 0, 0, 0, 8'hFF, 8'h00, 8'h00, 8'h00);
    step(2);
    check("sat_maxgain", mixed, 32767);

    // Four-channel sum.
    set_in(100, 200, -50, 7, 8'h10, 8'h10, 8'h10, 8'h10);
    step(2);
    check("sum4", mixed, 257);

    // cen=0 holds everything while ch0 changes.
    cen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ch0 = 16'(i * 1000 + 5);
      step(1);
    end
    check("cen_hold", mixed, 257);
    ch0 = 16'sd1000;
    cen = 1'b1;
    step(1);
    check("cen_resume_1tick", mixed, 257);
    step(1);
    check("cen_resume_2tick", mixed, 1157);

    // Reset mid-stream, asserted together with cen.
    rst = 1'b1;
    step(1);
    check("midrst", mixed, 0);
    rst = 1'b0;
    step(1);
    check("midrst_release_1tick", mixed, 0);
    step(1);
    check("midrst_release_2tick", mixed, 1157);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/jt12_gain_mixer.md
Name: jt12_gain_mixer

Overview:
Four-channel signed audio mixer with a per-channel 8-bit gain and a saturating output. It sits after the FM/OPL/PSG sound sources and produces the single mono sample fed to the board's audio output. Each channel has its own input width. Every channel is MSB-aligned to the output width, scaled by its gain, summed, and clipped.

Parameters:
w0, 16, width of ch0 (signed)
w1, 16, width of ch1 (signed)
w2, 16, width of ch2 (signed)
w3, 16, width of ch3 (signed)
wout, 16, width of mixed output (signed); every wi must be in the range 2..wout

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
cen  in  1  clock enable; the pipeline advances only on clk edges with cen=1
ch0  in  w0  signed channel 0 sample
ch1  in  w1  signed channel 1 sample
ch2  in  w2  signed channel 2 sample
ch3  in  w3  signed channel 3 sample
gain0  in  8  unsigned gain for ch0, 4.4 fixed point (0x10 = 1.0, 0xFF = 15.9375)
gain1  in  8  unsigned gain for ch1, same format
gain2  in  8  unsigned gain for ch2, same format
gain3  in  8  unsigned gain for ch3, same format
mixed  out  wout  signed, saturated mix

Behaviour:
- One clock domain; rst is synchronous and active-high and takes priority over cen.
- Alignment: each chN is left-shifted by (wout - wN) with zero fill, so its MSB lands on bit wout-1. The sign is preserved. Example: an 11-bit input with wout=16 is shifted left by 5.
- Gain: gainN is zero-extended to 9-bit signed before multiplying, so the gain is never negative. prodN = aligned_chN * gainN, held at wout+9 bits signed.
- Stage 1: on clk with cen=1, register prod0..prod3.
- Stage 2: on clk with cen=1:
  - sum = prod0+prod1+prod2+prod3, computed at wout+11 bits signed, so it never overflows internally.
  - shifted = sum >>> 4, an arithmetic shift that rounds toward -infinity.
  - Saturate shifted to the range [-2^(wout-1), 2^(wout-1)-1] and register the result into mixed.
- Latency: a change on the inputs appears on mixed after exactly 2 cen-qualified clocks. Inputs are sampled only on cen clocks.
- cen=0: every register holds its value and mixed is stable.
- Reset: both pipeline stages and mixed go to 0 on the first clk edge with rst=1, independent of cen. After rst is released, mixed stays 0 until new data has passed both stages (2 cen ticks).
- Simultaneous rst and cen: reset wins.
- A gain of 0 removes the channel from the sum entirely.
- The datapath is purely combinational between the two registers: no FSM, no accumulation across samples.

Test Plan:
1. Unity: gain0=0x10, all other gains 0, ch0=1234. After 2 cen ticks, mixed=1234. With ch0=-1234, mixed=-1234.
2. Alignment (w2=11, w3=8, wout=16): ch2=100 with gain2=0x10 gives mixed=3200. ch3=-128 with gain3=0x10 gives mixed=-32768.
3. Gain scaling: ch0=1000 with gain0=0x80 gives 8000. ch0=1000 with gain0=0x08 gives 500. ch0=-3 with gain0=0x08 gives -2, confirming the arithmetic floor.
4. Saturation: ch0=ch1=30000 with gains 0x10 gives mixed=32767. ch0=ch1=-30000 gives -32768. ch0=32767 with gain0=0xFF gives 32767.
5. Sum of all four channels at wout=16, w0..w3=16, all gains 0x10: ch0..ch3 = 100, 200, -50, 7 gives mixed=257.
6. Control:
   - Hold cen=0 for 10 clocks while changing ch0; mixed stays unchanged.
   - Assert rst for 1 clock mid-stream; mixed becomes 0 on the next edge.
   - mixed then returns to the correct value 2 cen ticks after rst is released.
